// File: rtl/sc_regbackg_bank.sv
// Frogger playfield background bank: ROWS rotating lane patterns with per-lane
// speed/direction and a sequential per-level reload FSM.
module sc_regbackg_bank #(
  parameter int DATAWIDTH = 8,
  parameter int ROWS = 4,
  parameter int LEVELS = 4,
  parameter logic [LEVELS*ROWS*DATAWIDTH-1:0] LEVEL_INIT = '0,
  parameter logic [ROWS-1:0] ROW_DIR = '0,
  parameter logic [ROWS*4-1:0] ROW_PERIOD = '0,
  localparam int LVLW = (LEVELS > 1) ? $clog2(LEVELS) : 1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                      SC_RegBACKGTYPE_CLOCK_50,
  input  logic                      SC_RegBACKGTYPE_RESET_InHigh,
  input  logic                      clear_InLow,
  input  logic                      level_load_InLow,
  input  logic [LVLW-1:0]           level_In,
  input  logic                      wr_InLow,
  input  logic [RW-1:0]             wr_row_In,
  input  logic [DATAWIDTH-1:0]      data_InBUS,
  input  logic                      shift_tick_In,
  output logic [ROWS*DATAWIDTH-1:0] data_OutBUS,
  output logic [LVLW-1:0]           level_Out,
  output logic                      busy_Out,
  output logic                      done_Out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, stateNext;
  logic [RW-1:0]       idx, idxNext;
  logic [LVLW-1:0]     levelReg, levelNext;
  logic                busyReg, doneReg;
  logic                loadEn, idleEn, zeroCnt;
  logic [DATAWIDTH-1:0] lane [ROWS];
  logic [3:0]          cnt [ROWS];
  logic [ROWS-1:0]     rotHit;

  function automatic logic [LVLW-1:0] clampLevel(input logic [LVLW-1:0] l);
    if (int'(l) > LEVELS - 1)
      return LVLW'(LEVELS - 1);
    return l;
  endfunction

  function automatic logic [DATAWIDTH-1:0] initLane(input logic [LVLW-1:0] l, input int r);
    return LEVEL_INIT[(int'(l) * ROWS + r) * DATAWIDTH +: DATAWIDTH];
  endfunction

  function automatic logic [DATAWIDTH-1:0] rotLane(input logic [DATAWIDTH-1:0] v, input logic left);
    if (left)
      return {v[DATAWIDTH-2:0], v[DATAWIDTH-1]};
    return {v[0], v[DATAWIDTH-1:1]};
  endfunction

  always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
    if (SC_RegBACKGTYPE_RESET_InHigh) begin
      state    <= IDLE;
      idx      <= '0;
      levelReg <= '0;
      busyReg  <= 1'b0;
      doneReg  <= 1'b0;
    end else begin
      state    <= stateNext;
      idx      <= idxNext;
      levelReg <= levelNext;
      // Status flags trail the state by one edge; a clear suppresses any pending pulse.
      busyReg  <= clear_InLow && (state != IDLE);
      doneReg  <= clear_InLow && (state == DONE);
    end
  end

  always_comb begin
    stateNext = state;
    idxNext   = idx;
    levelNext = levelReg;
    loadEn    = 1'b0;
    idleEn    = 1'b0;
    zeroCnt   = 1'b0;
    if (!clear_InLow) begin
      stateNext = IDLE;
      idxNext   = '0;
    end else begin
      case (state)
        IDLE: begin
          idleEn = 1'b1;
          if (!level_load_InLow) begin
            levelNext = clampLevel(level_In);
            idxNext   = '0;
            stateNext = LOAD;
          end
        end
        LOAD: begin
          loadEn  = 1'b1;
          idxNext = idx + RW'(1);
          if (int'(idx) == ROWS - 1)
            stateNext = DONE;
        end
        DONE: begin
          zeroCnt   = 1'b1;
          stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++)
      rotHit[r] = shift_tick_In && (cnt[r] == ROW_PERIOD[r*4 +: 4]);
  end

  always_ff @(posedge SC_RegBACKGTYPE_CLOCK_50 or posedge SC_RegBACKGTYPE_RESET_InHigh) begin
    if (SC_RegBACKGTYPE_RESET_InHigh) begin
      for (int r = 0; r < ROWS; r++) begin
        lane[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        if (!clear_InLow) begin
          lane[r] <= initLane(levelReg, r);
          cnt[r]  <= '0;
        end else if (loadEn) begin
          if (int'(idx) == r)
            lane[r] <= initLane(levelReg, r);
        end else if (zeroCnt) begin
          cnt[r] <= '0;
        end else if (idleEn) begin
          if (shift_tick_In)
            cnt[r] <= rotHit[r] ? 4'd0 : cnt[r] + 4'd1;
          // A direct write wins over rotation, but the divider still advances.
          if (!wr_InLow && int'(wr_row_In) == r)
            lane[r] <= data_InBUS;
          else if (rotHit[r])
            lane[r] <= rotLane(lane[r], ROW_DIR[r]);
        end
      end
    end
  end

  for (genvar g = 0; g < ROWS; g++) begin : g_out
    assign data_OutBUS[g*DATAWIDTH +: DATAWIDTH] = lane[g];
  end

  assign level_Out = levelReg;
  assign busy_Out  = busyReg;
  assign done_Out  = doneReg;

endmodule

// File: tb/tb_sc_regbackg_bank.sv
// Directed bench for sc_regbackg_bank: a 4-lane instance for load/rotate/clear/reset
// and a 3-lane instance for divider periods and out-of-range writes.
module tb_sc_regbackg_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clearN = 1'b1;
  logic        loadN = 1'b1;
  logic [1:0]  levelIn = 2'd0;
  logic        wrN = 1'b1;
  logic [1:0]  wrRow = 2'd0;
  logic [7:0]  wrData = 8'd0;
  logic        tick = 1'b0;
  logic [31:0] dataOut;
  logic [1:0]  levelOut;
  logic        busy, done;

  logic        wr3N = 1'b1;
  logic        tick3 = 1'b0;
  logic        hold3 = 1'b1;
  logic [23:0] data3;
  logic [1:0]  level3;
  logic        busy3, done3;

  int nChecks = 0;
  int nFails = 0;

  logic [23:0] exp3 [9] = '{24'h000102, 24'h000104, 24'h008008, 24'h008010, 24'h008020,
                            24'h004040, 24'h004080, 24'h004001, 24'h002002};

  always #5 clk = ~clk;

  sc_regbackg_bank #(
    .DATAWIDTH(8), .ROWS(4), .LEVELS(4),
    .LEVEL_INIT(128'h3CC35AA5_0FF01881_88442211_08040201),
    .ROW_DIR(4'b0101),
    .ROW_PERIOD(16'h0000)
  ) u_dut (
    .SC_RegBACKGTYPE_CLOCK_50(clk),
    .SC_RegBACKGTYPE_RESET_InHigh(rst),
    .clear_InLow(clearN),
    .level_load_InLow(loadN),
    .level_In(levelIn),
    .wr_InLow(wrN),
    .wr_row_In(wrRow),
    .data_InBUS(wrData),
    .shift_tick_In(tick),
    .data_OutBUS(dataOut),
    .level_Out(levelOut),
    .busy_Out(busy),
    .done_Out(done)
  );

  sc_regbackg_bank #(
    .DATAWIDTH(8), .ROWS(3), .LEVELS(4),
    .ROW_DIR(3'b001),
    .ROW_PERIOD(12'h020)
  ) u_dut3 (
    .SC_RegBACKGTYPE_CLOCK_50(clk),
    .SC_RegBACKGTYPE_RESET_InHigh(rst),
    .clear_InLow(hold3),
    .level_load_InLow(hold3),
    .level_In(levelIn),
    .wr_InLow(wr3N),
    .wr_row_In(wrRow),
    .data_InBUS(wrData),
    .shift_tick_In(tick3),
    .data_OutBUS(data3),
    .level_Out(level3),
    .busy_Out(busy3),
    .done_Out(done3)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic writeLane(input logic [1:0] row, input logic [7:0] val);
    wrN = 1'b0; wrRow = row; wrData = val;
    step();
    wrN = 1'b1;
  endtask

  initial begin
    // Reset with lanes preloaded to FF
    step(); step();
    rst = 1'b0;
    step();
    for (int r = 0; r < 4; r++) writeLane(2'(r), 8'hFF);
    checkVal("preload", dataOut, 32'hFFFFFFFF);
    rst = 1'b1;
    #2;
    checkVal("rst_held_data", dataOut, 32'h0);
    checkVal("rst_held_level", 32'(levelOut), 32'd0);
    checkVal("rst_held_busy", 32'(busy), 32'd0);
    checkVal("rst_held_done", 32'(done), 32'd0);
    step();
    rst = 1'b0;
    step();
    checkVal("rst_rel_data", dataOut, 32'h0);
    checkVal("rst_rel_busy", 32'(busy), 32'd0);
    checkVal("rst_rel_done", 32'(done), 32'd0);
    checkVal("rst3_level", 32'(level3), 32'd0);
    checkVal("rst3_busy", 32'({busy3, done3}), 32'd0);

    // Level 2 load, one lane per cycle, second request while busy ignored
    levelIn = 2'd2; loadN = 1'b0;
    step();
    loadN = 1'b1;
    checkVal("load_level", 32'(levelOut), 32'd2);
    checkVal("load_n0_data", dataOut, 32'h0);
    checkVal("load_n0_busy", 32'(busy), 32'd0);
    step();
    checkVal("load_lane0", dataOut, 32'h00000081);
    checkVal("load_n1_busy", 32'(busy), 32'd1);
    levelIn = 2'd1; loadN = 1'b0;
    step();
    checkVal("load_lane1", dataOut, 32'h00001881);
    checkVal("load_n2_done", 32'(done), 32'd0);
    step();
    loadN = 1'b1;
    checkVal("load_lane2", dataOut, 32'h00F01881);
    step();
    checkVal("load_lane3", dataOut, 32'h0FF01881);
    checkVal("load_n4_done", 32'(done), 32'd0);
    checkVal("load_n4_busy", 32'(busy), 32'd1);
    step();
    checkVal("load_n5_done", 32'(done), 32'd1);
    checkVal("load_n5_busy", 32'(busy), 32'd1);
    checkVal("load_n5_level", 32'(levelOut), 32'd2);
    step();
    checkVal("load_n6_done", 32'(done), 32'd0);
    checkVal("load_n6_busy", 32'(busy), 32'd0);
    checkVal("load_n6_data", dataOut, 32'h0FF01881);

    // Direction: lanes 0,2 left, lanes 1,3 right
    for (int r = 0; r < 4; r++) writeLane(2'(r), 8'h81);
    checkVal("all81", dataOut, 32'h81818181);
    tick = 1'b1;
    step();
    tick = 1'b0;
    checkVal("rot_dir", dataOut, 32'hC003C003);

    // Write and tick in the same cycle
    wrN = 1'b0; wrRow = 2'd3; wrData = 8'hAA; tick = 1'b1;
    step();
    wrN = 1'b1; tick = 1'b0;
    checkVal("wr_tick", dataOut, 32'hAA066006);

    // Clear during LOAD after lane 1 is written
    levelIn = 2'd2; loadN = 1'b0;
    step();
    loadN = 1'b1;
    step(); step();
    checkVal("clr_partial", dataOut, 32'hAA061881);
    clearN = 1'b0;
    step();
    clearN = 1'b1;
    checkVal("clr_data", dataOut, 32'h0FF01881);
    checkVal("clr_busy", 32'(busy), 32'd0);
    checkVal("clr_done", 32'(done), 32'd0);
    step();
    checkVal("clr_done_next", 32'(done), 32'd0);
    checkVal("clr_hold", dataOut, 32'h0FF01881);
    writeLane(2'd0, 8'h55);
    checkVal("clr_idle_wr", dataOut, 32'h0FF01855);

    // Reset mid-LOAD
    levelIn = 2'd1; loadN = 1'b0;
    step();
    loadN = 1'b1;
    step();
    checkVal("rl_lane0", dataOut, 32'h0FF01811);
    rst = 1'b1;
    #2;
    checkVal("rl_data", dataOut, 32'h0);
    checkVal("rl_level", 32'(levelOut), 32'd0);
    checkVal("rl_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b0;
    step(); step();
    checkVal("rl_after", dataOut, 32'h0);
    checkVal("rl_done", 32'(done), 32'd0);

    // 3-lane instance: out-of-range write and divider periods
    wr3N = 1'b0; wrRow = 2'd0; wrData = 8'h01;
    step();
    wrRow = 2'd1;
    step();
    wrRow = 2'd3; wrData = 8'hAA;
    step();
    wr3N = 1'b1;
    checkVal("oor_write", 32'(data3), 32'h000101);
    tick3 = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      checkVal($sformatf("period_tick%0d", k + 1), 32'(data3), 32'(exp3[k]));
    end
    tick3 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
